data_cache_controller: RTL and testbench

Two-way set-associative, write-through, no-write-allocate data cache between the ARM pipeline MEM stage and the SRAM controller. It serves MEM-stage loads from on-chip storage, forwards every store and every miss to the SRAM controller over its wrEn/rdEn/ready handshake, and freezes the pipeline through `ready` while an SRAM transaction is outstanding. Each line holds two 32-bit words, so a read miss costs two sequential SRAM reads.

---
 rtl/data_cache_controller.sv | 179 +++++++++++++++++
 tb/tb_data_cache_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_controller.sv
// data_cache_controller: two-way set-associative, write-through,
// no-write-allocate data cache between the MEM stage and the SRAM controller.
// Each line holds two 32-bit words; a read miss costs two SRAM reads.
// Optional build macro CACHE_STATS_EN adds saturating hit/miss counters
// (ports hit_count / miss_count).
module data_cache_controller #(
    parameter int unsigned SETS  = 64,
    parameter int unsigned TAG_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_wrEn,
    output logic        sram_rdEn,
    output logic [31:0] sram_address,
    output logic [31:0] sram_writeData,
    input  logic [31:0] sram_readData,
    input  logic        sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_LO = IDX_W + 3;

    typedef enum logic [2:0] {IDLE, FILL0, FILL1, WRITE, DONE} state_e;

    state_e state_q, state_d;

    // Per-way storage; word index 0 is the lower word of the line
    logic [SETS-1:0]  valid_q [2];
    logic [SETS-1:0]  lru_q;
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic [31:0]      data_q  [2][SETS][2];
    logic [31:0]      fill_buf_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             wsel;
    logic             hit0, hit1, hit, hit_way;
    logic [31:0]      hit_word;
    logic             req_rd, req_wr;
    logic             rd_hit_acc, fill_done, wr_done, fill0_done;
    logic             unused_addr_bits;

    assign idx  = address[IDX_W+2:3];
    assign tag  = address[TAG_LO+TAG_W-1:TAG_LO];
    assign wsel = address[2];
    assign unused_addr_bits = ^address[1:0];

    // Requests are masked during reset so outputs show reset values immediately
    assign req_wr = !rst && MEM_W_EN;
    assign req_rd = !rst && MEM_R_EN && !MEM_W_EN;

    // Tag lookup for the currently presented address
    always_comb begin
        hit0     = valid_q[0][idx] && (tag_q[0][idx] == tag);
        hit1     = valid_q[1][idx] && (tag_q[1][idx] == tag);
        hit      = hit0 || hit1;
        hit_way  = hit1;
        hit_word = data_q[hit_way][idx][wsel];
    end

    assign rd_hit_acc = (state_q == IDLE)  && req_rd && hit;
    assign fill0_done = (state_q == FILL0) && sram_ready;
    assign fill_done  = (state_q == FILL1) && sram_ready;
    assign wr_done    = (state_q == WRITE) && sram_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_wr)              state_d = WRITE;
                else if (req_rd && !hit) state_d = FILL0;
            end
            FILL0:   if (sram_ready) state_d = FILL1;
            FILL1:   if (sram_ready) state_d = DONE;
            WRITE:   if (sram_ready) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: pipeline handshake and SRAM request signals
    always_comb begin
        ready          = 1'b0;
        rdata          = '0;
        sram_wrEn      = 1'b0;
        sram_rdEn      = 1'b0;
        sram_address   = '0;
        sram_writeData = '0;
        case (state_q)
            IDLE: begin
                ready = !(req_wr || (req_rd && !hit));
                rdata = (req_rd && hit) ? hit_word : '0;
            end
            FILL0: begin
                sram_rdEn    = 1'b1;
                sram_address = {address[31:3], 3'b000};
            end
            FILL1: begin
                sram_rdEn    = 1'b1;
                sram_address = {address[31:3], 3'b100};
            end
            WRITE: begin
                sram_wrEn      = 1'b1;
                sram_address   = {address[31:2], 2'b00};
                sram_writeData = wdata;
            end
            DONE: begin
                // The freshly filled line now hits, so the normal lookup serves the load
                ready = 1'b1;
                rdata = (req_rd && hit) ? hit_word : '0;
            end
            default: ready = 1'b1;
        endcase
    end

    // Valid bits, LRU bits and the word0 fill buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned w = 0; w < 2; w++) valid_q[w] <= '0;
            lru_q      <= '0;
            fill_buf_q <= '0;
        end else begin
            if (fill0_done) fill_buf_q <= sram_readData;
            if (fill_done) begin
                valid_q[lru_q[idx]][idx] <= 1'b1;
                lru_q[idx]               <= ~lru_q[idx];
            end
            if (rd_hit_acc || (wr_done && hit)) lru_q[idx] <= ~hit_way;
        end
    end

    // Tag and data arrays; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[lru_q[idx]][idx]     <= tag;
            data_q[lru_q[idx]][idx][0] <= fill_buf_q;
            data_q[lru_q[idx]][idx][1] <= sram_readData;
        end
        if (wr_done && hit) data_q[hit_way][idx][wsel] <= wdata;
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    // Saturating counters: read hits in IDLE, read misses on entry to FILL0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (rd_hit_acc && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + 16'd1;
            if ((state_q == IDLE) && (state_d == FILL0) && (miss_cnt_q != '1))
                miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache_controller.sv
// Directed bench for data_cache_controller: vector table plus hand-written
// sequences for fill addressing, reset during a fill and optional statistics.
module tb_data_cache_controller;

    logic        clk;
    logic        rst;
    logic        MEM_R_EN, MEM_W_EN;
    logic [31:0] address, wdata, rdata;
    logic        ready;
    logic        sram_wrEn, sram_rdEn;
    logic [31:0] sram_address, sram_writeData, sram_readData;
    logic        sram_ready;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    int tests  = 0;
    int failed = 0;
    int lat    = 2;
    int both_en_seen = 0;
    int wr_cnt = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;
    logic [31:0] rd_log[$];
    logic [31:0] mem [logic [31:0]];

    data_cache_controller #(.SETS(64), .TAG_W(10)) dut (
        .clk            (clk),
        .rst            (rst),
        .MEM_R_EN       (MEM_R_EN),
        .MEM_W_EN       (MEM_W_EN),
        .address        (address),
        .wdata          (wdata),
        .rdata          (rdata),
        .ready          (ready),
        .sram_wrEn      (sram_wrEn),
        .sram_rdEn      (sram_rdEn),
        .sram_address   (sram_address),
        .sram_writeData (sram_writeData),
        .sram_readData  (sram_readData),
        .sram_ready     (sram_ready)
`ifdef CACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A0000;
    endfunction

    // SRAM model: pulses sram_ready after 'lat' cycles of an asserted enable
    initial begin
        int cnt;
        cnt = 0;
        sram_ready = 1'b0;
        sram_readData = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sram_ready) cnt = 0;
            sram_ready = 1'b0;
            if (sram_rdEn && sram_wrEn) both_en_seen++;
            if (rst || !(sram_rdEn || sram_wrEn)) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= lat) begin
                    sram_ready = 1'b1;
                    if (sram_rdEn) begin
                        sram_readData = mem_rd(sram_address);
                        rd_log.push_back(sram_address);
                    end else begin
                        mem[sram_address] = sram_writeData;
                        last_wr_addr = sram_address;
                        last_wr_data = sram_writeData;
                        wr_cnt++;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one request, count cycles with ready=0, return rdata when ready
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output int stall);
        @(negedge clk);
        MEM_R_EN = r;
        MEM_W_EN = w;
        address  = a;
        wdata    = d;
        #1;
        stall = 0;
        while (!ready && stall < 100) begin
            @(negedge clk);
            #1;
            stall++;
        end
        if (stall >= 100) begin
            tests++;
            failed++;
            $display("FAIL timeout: ready stuck low for addr %h", a);
        end
        rd = rdata;
    endtask

    task automatic go_idle();
        @(negedge clk);
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
    endtask

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        int          exp_stall;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] got;
        int          stall;
        int          wr_before;
        bit          found;

        rst = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; address = '0; wdata = '0;
        mem[32'h10] = 32'hAAAA0000;
        mem[32'h14] = 32'hBBBB0000;

        // Reset values
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_rdata", rdata, 32'h0);
        check("rst_sram_en", {30'b0, sram_wrEn, sram_rdEn}, 32'd0);
        check("rst_sram_addr", sram_address, 32'h0);
        check("rst_sram_wdata", sram_writeData, 32'h0);
        rst = 1'b0;

        // lat=2: read miss stalls 2+2+1, write stalls 2+1, hit stalls 0
        vecs.push_back(vec_t'{1'b0, 1'b0, 32'h000, 32'h0,        32'h00000000, 0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h010, 32'h0,        32'hAAAA0000, 5});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h014, 32'h0,        32'hBBBB0000, 0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h210, 32'h0,        32'h5A5A0210, 5});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h410, 32'h0,        32'h5A5A0410, 5});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h210, 32'h0,        32'h5A5A0210, 0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h010, 32'h0,        32'hAAAA0000, 5});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h014, 32'h12345678, 32'h00000000, 3});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h014, 32'h0,        32'h12345678, 0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h010, 32'h0,        32'hAAAA0000, 0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 32'h800, 32'hCAFEF00D, 32'h00000000, 3});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h800, 32'h0,        32'hCAFEF00D, 5});
        vecs.push_back(vec_t'{1'b1, 1'b0, 32'h804, 32'h0,        32'h5A5A0804, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            wr_before = wr_cnt;
            access(vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].wd, got, stall);
            check($sformatf("v%0d_stall", i), stall, vecs[i].exp_stall);
            if (vecs[i].r) check($sformatf("v%0d_rdata", i), got, vecs[i].exp_rd);
            if (vecs[i].w) begin
                check($sformatf("v%0d_wr_cnt", i), wr_cnt - wr_before, 32'd1);
                check($sformatf("v%0d_wr_addr", i), last_wr_addr, vecs[i].addr);
                check($sformatf("v%0d_wr_data", i), last_wr_data, vecs[i].wd);
            end
        end
        go_idle();

        // The cold read filled 0x10 then 0x14
        check("fill0_addr", (rd_log.size() > 0) ? rd_log[0] : 32'hFFFFFFFF, 32'h10);
        check("fill1_addr", (rd_log.size() > 1) ? rd_log[1] : 32'hFFFFFFFF, 32'h14);
        check("no_dual_enable", both_en_seen, 32'd0);

        // Reset during FILL1 aborts asynchronously
        lat = 4;
        @(negedge clk);
        MEM_R_EN = 1'b1;
        address  = 32'h1000;
        found    = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            #1;
            if (sram_rdEn && sram_address == 32'h1004) found = 1'b1;
        end
        check("reach_fill1", {31'b0, found}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_ready", {31'b0, ready}, 32'd1);
        check("abort_rdata", rdata, 32'h0);
        check("abort_sram_en", {30'b0, sram_wrEn, sram_rdEn}, 32'd0);
        check("abort_sram_addr", sram_address, 32'h0);
        MEM_R_EN = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        access(1'b1, 1'b0, 32'h1000, 32'h0, got, stall);
        check("refill_stall", stall, 32'd9);
        check("refill_rdata", got, 32'h5A5A1000);
        go_idle();

`ifdef CACHE_STATS_EN
        lat = 1;
        access(1'b1, 1'b0, 32'h2000, 32'h0, got, stall);
        access(1'b1, 1'b0, 32'h3000, 32'h0, got, stall);
        access(1'b1, 1'b0, 32'h2000, 32'h0, got, stall);
        access(1'b1, 1'b0, 32'h2004, 32'h0, got, stall);
        access(1'b1, 1'b0, 32'h3000, 32'h0, got, stall);
        access(1'b1, 1'b0, 32'h3004, 32'h0, got, stall);
        access(1'b1, 1'b0, 32'h2000, 32'h0, got, stall);
        go_idle();
        @(negedge clk);
        check("miss_count", {16'b0, miss_count}, 32'd3);
        check("hit_count", {16'b0, hit_count}, 32'd5);
        for (int i = 0; i < 65530; i++) access(1'b1, 1'b0, 32'h2000, 32'h0, got, stall);
        go_idle();
        @(negedge clk);
        check("hit_count_max", {16'b0, hit_count}, 32'h0000FFFF);
        access(1'b1, 1'b0, 32'h2000, 32'h0, got, stall);
        go_idle();
        @(negedge clk);
        check("hit_count_sat", {16'b0, hit_count}, 32'h0000FFFF);
        check("miss_count_final", {16'b0, miss_count}, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
